uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
- Sits directly downstream of the UART receiver in the program-load path and drives the instruction-memory write port.
- Consumes received bytes and assembles every 4 consecutive bytes, least-significant byte first, into one 32-bit instruction.
- Writes each instruction to sequential instruction-memory addresses starting at 0.
- Asserts write_done when the end-of-program marker word is received or memory is full. The core is then released from reset.

Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- MEM_DEPTH, 256: number of writable words; must be ≤ 2**ADDR_W.
- END_MARKER, 32'hFFFFFFFF: word that terminates loading; never written to memory.
- TIMEOUT_CYC, 1000000: idle cycles after which a partial word is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- uart_rx_valid  in  1  UART byte-valid; may stay high for more than one cycle
- uart_rx_data  in  8  received byte; stable while uart_rx_valid is high
- uart_rx_break  in  1  BREAK detected on the line
- imem_we  out  1  instruction-memory write strobe, one-cycle pulse
- imem_addr  out  ADDR_W  word address for the write
- imem_wdata  out  32  instruction data for the write
- word_count  out  ADDR_W+1  number of words written so far
- write_done  out  1  loading finished; sticky until rst
- mem_full  out  1  loading ended because all MEM_DEPTH words were written
- err_timeout  out  1  one-cycle pulse when a partial word is discarded by timeout

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0, byte_idx=0, shift register=0, timeout counter=0, prev_valid=0, state=COLLECT.
  - Reset mid-word or mid-write discards all progress.
- Byte acceptance:
  - A byte is accepted on a cycle where uart_rx_valid=1 and prev_valid=0 (rising-edge detect).
  - prev_valid is a registered copy of uart_rx_valid, updated every cycle.
  - Bytes are accepted only in state COLLECT.
- Assembly: byte k (k = 0..3) of a word is placed in bits [8k+7:8k].
- COLLECT state:
  - Each accepted byte stores at byte_idx, then byte_idx increments.
  - On acceptance of byte 3, compare the assembled word with END_MARKER:
    - Equal: go to DONE next cycle. No imem_we pulse; write_done=1 from the next cycle.
    - Not equal: go to WRITE. byte_idx returns to 0.
- WRITE state (one cycle):
  - imem_we=1, imem_addr=word_count[ADDR_W-1:0], imem_wdata=assembled word.
  - Latency: the 4th byte is accepted on cycle N; imem_we is high on cycle N+1.
  - On leaving WRITE, word_count increments.
  - If word_count reaches MEM_DEPTH: go to DONE with write_done=1 and mem_full=1. Otherwise return to COLLECT.
- A valid edge arriving during WRITE is still accepted (not lost): it is latched as byte 0 of the next word.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- DONE state: all further bytes and breaks are ignored, no writes occur, outputs are held. Only rst leaves DONE.
- uart_rx_break=1 in COLLECT:
  - Clears byte_idx and the shift register; the partial word is discarded.
  - word_count is unchanged; no error pulse.
  - If break and a valid edge occur in the same cycle, break wins and the byte is dropped.
- Timeout:
  - While byte_idx≠0 in COLLECT, the counter increments each cycle and clears on every accepted byte.
  - When the counter reaches TIMEOUT_CYC-1: byte_idx clears, err_timeout pulses for 1 cycle, and the counter clears.
  - The counter is held at 0 while byte_idx=0.
- A word of 32'h00000000 is an ordinary instruction and is written.
- word_count saturates at MEM_DEPTH; addresses never wrap.

Test Plan:
- Reset, then send bytes 13,01,01,FD → one imem_we pulse with addr 0, wdata 32'hFD010113, one cycle after the 4th valid edge; word_count=1.
- Send words 32'h00000000, 32'h02812623, 32'hFFFFFFFF (4 bytes each, LSB first):
  - Required: writes at addr 0 and addr 1 only.
  - Required: write_done=1 and mem_full=0; subsequent bytes produce no imem_we.
- Hold uart_rx_valid high for 5 cycles per byte → each byte is counted once; the word assembles correctly.
- Send 2 bytes, pulse uart_rx_break, then send 78,56,34,12 → a single write of 32'h12345678 at addr 0.
- With TIMEOUT_CYC=100:
  - Send 3 bytes, then idle 100 cycles: err_timeout pulses exactly once and there is no write.
  - Then send 4 bytes: a normal write occurs at addr 0.
- With MEM_DEPTH=4: send 4 non-marker words → writes at addr 0..3, then write_done=1, mem_full=1. A 5th word produces no write.
- Assert rst after 2 bytes of a word: outputs return to 0 and the next 4 bytes are written at addr 0.

Source files
------------

// File: rtl/uart_imem_loader_if.sv
// Byte stream from the UART receiver and the instruction-memory write port
// of the program loader, bundled for connection to uart_imem_loader.
interface uart_imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              uart_rx_valid;
    logic [7:0]        uart_rx_data;
    logic              uart_rx_break;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              write_done;
    logic              mem_full;
    logic              err_timeout;

    // master: the UART/test side that feeds bytes and observes the writes
    modport master (
        output uart_rx_valid, uart_rx_data, uart_rx_break,
        input  imem_we, imem_addr, imem_wdata, word_count,
        input  write_done, mem_full, err_timeout
    );

    // slave: the loader itself
    modport slave (
        input  uart_rx_valid, uart_rx_data, uart_rx_break,
        output imem_we, imem_addr, imem_wdata, word_count,
        output write_done, mem_full, err_timeout
    );
endinterface

// File: rtl/uart_imem_loader.sv
// Assembles UART bytes (LSB first) into 32-bit instructions and writes them to
// sequential instruction-memory words until an end marker or a full memory.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | gathering bytes of the current word, timeout running
// WRITE   | one-cycle instruction-memory write of the assembled word
// DONE    | loading finished, everything frozen until rst
module uart_imem_loader #(
    parameter int          ADDR_W      = 8,
    parameter int          MEM_DEPTH   = 256,
    parameter logic [31:0] END_MARKER  = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    uart_imem_loader_if.slave   bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              prev_valid;
    logic [1:0]        byte_idx, byte_idx_nx;
    logic [31:0]       shift_reg, shift_nx;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nx;
    logic [ADDR_W:0]   word_count, word_count_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [31:0]       wdata_q, wdata_nx;
    logic              done_q, done_nx;
    logic              full_q, full_nx;
    logic              tmo_err_q, tmo_err_nx;

    logic              byte_edge;
    logic [31:0]       with_byte;
    logic [ADDR_W:0]   wc_inc;

    assign byte_edge = bus.uart_rx_valid & ~prev_valid;
    assign wc_inc    = word_count + 1'b1;

    // Shift register with the incoming byte dropped into its lane
    always_comb begin
        with_byte = shift_reg;
        case (byte_idx)
            2'd0:    with_byte[7:0]   = bus.uart_rx_data;
            2'd1:    with_byte[15:8]  = bus.uart_rx_data;
            2'd2:    with_byte[23:16] = bus.uart_rx_data;
            default: with_byte[31:24] = bus.uart_rx_data;
        endcase
    end

    always_comb begin
        state_nx      = state;
        byte_idx_nx   = byte_idx;
        shift_nx      = shift_reg;
        tmo_nx        = tmo_cnt;
        word_count_nx = word_count;
        addr_nx       = addr_q;
        wdata_nx      = wdata_q;
        done_nx       = done_q;
        full_nx       = full_q;
        tmo_err_nx    = 1'b0;

        case (state)
            COLLECT: begin
                if (bus.uart_rx_break) begin
                    byte_idx_nx = 2'd0;
                    shift_nx    = '0;
                    tmo_nx      = '0;
                end else if (byte_edge) begin
                    tmo_nx   = '0;
                    shift_nx = with_byte;
                    if (byte_idx == 2'd3) begin
                        byte_idx_nx = 2'd0;
                        if (with_byte == END_MARKER) begin
                            state_nx = DONE;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = WRITE;
                            addr_nx  = word_count[ADDR_W-1:0];
                            wdata_nx = with_byte;
                        end
                    end else begin
                        byte_idx_nx = byte_idx + 2'd1;
                    end
                end else if (byte_idx != 2'd0) begin
                    if (tmo_cnt == TMO_LAST) begin
                        byte_idx_nx = 2'd0;
                        shift_nx    = '0;
                        tmo_nx      = '0;
                        tmo_err_nx  = 1'b1;
                    end else begin
                        tmo_nx = tmo_cnt + 1'b1;
                    end
                end
            end
            WRITE: begin
                word_count_nx = wc_inc;
                if (wc_inc == DEPTH_CNT) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    full_nx  = 1'b1;
                end else begin
                    state_nx = COLLECT;
                    // an edge here starts the next word rather than being lost
                    if (byte_edge) begin
                        shift_nx[7:0] = bus.uart_rx_data;
                        byte_idx_nx   = 2'd1;
                        tmo_nx        = '0;
                    end
                end
            end
            DONE: begin
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            prev_valid <= 1'b0;
            byte_idx   <= 2'd0;
            shift_reg  <= '0;
            tmo_cnt    <= '0;
            word_count <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            prev_valid <= bus.uart_rx_valid;
            byte_idx   <= byte_idx_nx;
            shift_reg  <= shift_nx;
            tmo_cnt    <= tmo_nx;
            word_count <= word_count_nx;
            addr_q     <= addr_nx;
            wdata_q    <= wdata_nx;
            done_q     <= done_nx;
            full_q     <= full_nx;
            tmo_err_q  <= tmo_err_nx;
        end
    end

    assign bus.imem_we     = (state == WRITE);
    assign bus.imem_addr   = addr_q;
    assign bus.imem_wdata  = wdata_q;
    assign bus.word_count  = word_count;
    assign bus.write_done  = done_q;
    assign bus.mem_full    = full_q;
    assign bus.err_timeout = tmo_err_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: directed scenarios plus randomized
// word streams checked against a word-level reference model.
module tb_uart_imem_loader;
    localparam int          ADDR_W      = 3;
    localparam int          MEM_DEPTH   = 4;
    localparam logic [31:0] MARK        = 32'hFFFF_FFFF;
    localparam int          TIMEOUT_CYC = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_imem_loader #(
        .ADDR_W(ADDR_W),
        .MEM_DEPTH(MEM_DEPTH),
        .END_MARKER(MARK),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int                err_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.imem_we === 1'b1) begin
                wa_q.push_back(bus.imem_addr);
                wd_q.push_back(bus.imem_wdata);
            end
            if (bus.err_timeout === 1'b1) err_cnt++;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data  = 8'h00;
        bus.uart_rx_break = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
        err_cnt = 0;
    endtask

    // valid goes high just after a rising edge, stays for 'hold' cycles
    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk);
        #1;
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = b;
        repeat (hold) @(posedge clk);
        #1;
        bus.uart_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int hold, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], hold);
            repeat (gap) @(posedge clk);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'hA5;
        bus.uart_rx_break = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", bus.imem_we); end
        n_cmp++;
        if (bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_addr_data got %h/%h want 0/0", bus.imem_addr, bus.imem_wdata);
        end
        n_cmp++;
        if (bus.word_count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.word_count); end
        n_cmp++;
        if ({bus.write_done, bus.mem_full, bus.err_timeout} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags got %b want 000", {bus.write_done, bus.mem_full, bus.err_timeout});
        end
        bus.uart_rx_valid = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        send_byte(8'h13, 1);
        send_byte(8'h01, 1);
        send_byte(8'h01, 1);
        n_cmp++;
        if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL basic_early_we got %b want 0", bus.imem_we); end
        send_byte(8'hFD, 1);
        @(negedge clk);
        n_cmp++;
        if (bus.imem_we !== 1'b1 || bus.imem_addr !== 3'd0 || bus.imem_wdata !== 32'hFD010113) begin
            n_bad++;
            $display("FAIL basic_write got we=%b addr=%0d data=%h want we=1 addr=0 data=fd010113",
                     bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.imem_we !== 1'b0 || bus.word_count !== 4'd1) begin
            n_bad++; $display("FAIL basic_after got we=%b count=%0d want we=0 count=1", bus.imem_we, bus.word_count);
        end
        n_cmp++;
        if (bus.imem_addr !== 3'd0 || bus.imem_wdata !== 32'hFD010113) begin
            n_bad++; $display("FAIL basic_hold got %0d/%h want 0/fd010113", bus.imem_addr, bus.imem_wdata);
        end
    endtask

    task automatic test_marker();
        do_reset();
        send_word(32'h0000_0000, 1, 1);
        send_word(32'h0281_2623, 1, 1);
        send_word(MARK, 1, 1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wa_q.size() != 2) begin
            n_bad++; $display("FAIL marker_nwrites got %0d want 2", wa_q.size());
        end else begin
            n_cmp++;
            if (wa_q[0] !== 3'd0 || wd_q[0] !== 32'h0 || wa_q[1] !== 3'd1 || wd_q[1] !== 32'h0281_2623) begin
                n_bad++;
                $display("FAIL marker_writes got %0d:%h %0d:%h want 0:00000000 1:02812623",
                         wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
            end
        end
        n_cmp++;
        if (bus.write_done !== 1'b1 || bus.mem_full !== 1'b0 || bus.word_count !== 4'd2) begin
            n_bad++;
            $display("FAIL marker_flags got done=%b full=%b count=%0d want 1 0 2",
                     bus.write_done, bus.mem_full, bus.word_count);
        end
        send_word(32'h1122_3344, 1, 0);
        bus.uart_rx_break = 1'b1;
        @(posedge clk);
        #1;
        bus.uart_rx_break = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wa_q.size() != 2 || bus.write_done !== 1'b1 || bus.word_count !== 4'd2) begin
            n_bad++;
            $display("FAIL marker_frozen got writes=%0d done=%b count=%0d want 2 1 2",
                     wa_q.size(), bus.write_done, bus.word_count);
        end
    endtask

    task automatic test_long_valid();
        do_reset();
        send_word(32'hDEAD_BEEF, 5, 2);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wa_q.size() != 1 || bus.word_count !== 4'd1) begin
            n_bad++; $display("FAIL long_valid_count got writes=%0d count=%0d want 1 1", wa_q.size(), bus.word_count);
        end else begin
            n_cmp++;
            if (wa_q[0] !== 3'd0 || wd_q[0] !== 32'hDEAD_BEEF) begin
                n_bad++; $display("FAIL long_valid_data got %0d:%h want 0:deadbeef", wa_q[0], wd_q[0]);
            end
        end
    endtask

    task automatic test_break();
        do_reset();
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        @(posedge clk);
        #1;
        bus.uart_rx_break = 1'b1;
        @(posedge clk);
        #1;
        bus.uart_rx_break = 1'b0;
        send_word(32'h1234_5678, 1, 1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wa_q.size() != 1 || err_cnt != 0) begin
            n_bad++; $display("FAIL break_count got writes=%0d errs=%0d want 1 0", wa_q.size(), err_cnt);
        end else begin
            n_cmp++;
            if (wa_q[0] !== 3'd0 || wd_q[0] !== 32'h1234_5678) begin
                n_bad++; $display("FAIL break_data got %0d:%h want 0:12345678", wa_q[0], wd_q[0]);
            end
        end
        // break coinciding with a valid edge drops that byte
        @(posedge clk);
        #1;
        bus.uart_rx_break = 1'b1;
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h99;
        @(posedge clk);
        #1;
        bus.uart_rx_break = 1'b0;
        bus.uart_rx_valid = 1'b0;
        send_word(32'hCAFE_0001, 1, 0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wa_q.size() != 2) begin
            n_bad++; $display("FAIL break_edge_count got %0d want 2", wa_q.size());
        end else begin
            n_cmp++;
            if (wa_q[1] !== 3'd1 || wd_q[1] !== 32'hCAFE_0001) begin
                n_bad++; $display("FAIL break_edge_data got %0d:%h want 1:cafe0001", wa_q[1], wd_q[1]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'h03, 1);
        repeat (95) @(negedge clk);
        n_cmp++;
        if (err_cnt != 0) begin n_bad++; $display("FAIL timeout_early got %0d want 0", err_cnt); end
        repeat (15) @(negedge clk);
        n_cmp++;
        if (err_cnt != 1 || wa_q.size() != 0) begin
            n_bad++; $display("FAIL timeout_pulse got errs=%0d writes=%0d want 1 0", err_cnt, wa_q.size());
        end
        send_word(32'h0A0B_0C0D, 1, 1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wa_q.size() != 1) begin
            n_bad++; $display("FAIL timeout_recover_count got %0d want 1", wa_q.size());
        end else begin
            n_cmp++;
            if (wa_q[0] !== 3'd0 || wd_q[0] !== 32'h0A0B_0C0D) begin
                n_bad++; $display("FAIL timeout_recover_data got %0d:%h want 0:0a0b0c0d", wa_q[0], wd_q[0]);
            end
        end
        n_cmp++;
        if (err_cnt != 1) begin n_bad++; $display("FAIL timeout_once got %0d want 1", err_cnt); end
    endtask

    task automatic test_full();
        logic [31:0] words[5];
        do_reset();
        for (int i = 0; i < 5; i++) words[i] = 32'h1000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
        for (int i = 0; i < 5; i++) send_word(words[i], 1, 1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wa_q.size() != MEM_DEPTH) begin
            n_bad++; $display("FAIL full_nwrites got %0d want %0d", wa_q.size(), MEM_DEPTH);
        end else begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                n_cmp++;
                if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== words[i]) begin
                    n_bad++; $display("FAIL full_write%0d got %0d:%h want %0d:%h", i, wa_q[i], wd_q[i], i, words[i]);
                end
            end
        end
        n_cmp++;
        if (bus.write_done !== 1'b1 || bus.mem_full !== 1'b1 || bus.word_count !== 4'd4) begin
            n_bad++;
            $display("FAIL full_flags got done=%b full=%b count=%0d want 1 1 4",
                     bus.write_done, bus.mem_full, bus.word_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(32'h5555_5555, 1, 1);
        send_byte(8'h77, 1);
        send_byte(8'h66, 1);
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (bus.word_count !== '0 || bus.imem_wdata !== 32'h0 || bus.write_done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_clear got count=%0d data=%h done=%b want 0 0 0",
                     bus.word_count, bus.imem_wdata, bus.write_done);
        end
        send_word(32'h8765_4321, 1, 1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wa_q.size() != 1) begin
            n_bad++; $display("FAIL rst_mid_count got %0d want 1", wa_q.size());
        end else begin
            n_cmp++;
            if (wa_q[0] !== 3'd0 || wd_q[0] !== 32'h8765_4321) begin
                n_bad++; $display("FAIL rst_mid_data got %0d:%h want 0:87654321", wa_q[0], wd_q[0]);
            end
        end
    endtask

    // Model: words are written in order until the marker or MEM_DEPTH writes
    task automatic test_random();
        logic [31:0] words[$];
        logic [31:0] exp_q[$];
        logic        exp_done;
        logic        exp_full;
        int          n;
        int          r;
        for (int it = 0; it < 20; it++) begin
            do_reset();
            words.delete();
            exp_q.delete();
            exp_done = 1'b0;
            exp_full = 1'b0;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 7);
                if (r == 0)      words.push_back(MARK);
                else if (r == 1) words.push_back(32'h0);
                else             words.push_back($urandom);
            end
            foreach (words[i]) begin
                if (!exp_done) begin
                    if (words[i] == MARK) begin
                        exp_done = 1'b1;
                    end else begin
                        exp_q.push_back(words[i]);
                        if (exp_q.size() == MEM_DEPTH) begin
                            exp_done = 1'b1;
                            exp_full = 1'b1;
                        end
                    end
                end
            end
            foreach (words[i]) begin
                for (int k = 0; k < 4; k++) begin
                    send_byte(words[i][8*k +: 8], $urandom_range(1, 3));
                    repeat ($urandom_range(0, 20)) @(posedge clk);
                end
            end
            repeat (4) @(negedge clk);
            n_cmp++;
            if (wa_q.size() != exp_q.size()) begin
                n_bad++; $display("FAIL rand%0d_nwrites got %0d want %0d", it, wa_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_cmp++;
                    if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_q[i]) begin
                        n_bad++;
                        $display("FAIL rand%0d_write%0d got %0d:%h want %0d:%h", it, i, wa_q[i], wd_q[i], i, exp_q[i]);
                    end
                end
            end
            n_cmp++;
            if (bus.write_done !== exp_done || bus.mem_full !== exp_full ||
                bus.word_count !== (ADDR_W+1)'(exp_q.size())) begin
                n_bad++;
                $display("FAIL rand%0d_flags got done=%b full=%b count=%0d want %b %b %0d", it,
                         bus.write_done, bus.mem_full, bus.word_count, exp_done, exp_full, exp_q.size());
            end
        end
    endtask

    initial begin
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data  = 8'h00;
        bus.uart_rx_break = 1'b0;
        test_reset();
        test_basic();
        test_marker();
        test_long_valid();
        test_break();
        test_timeout();
        test_full();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
